uart_rx_fifo: RTL and testbench

Receive buffer stage directly downstream of the UART receiver. It captures each completed character (rsr_data plus parity/frame status) on the receiver's done indication into a 16-entry FIFO. It presents the head entry to the register interface as RBR and generates the RX-side LSR/interrupt status: data ready, overrun, error-in-FIFO and trigger level. It supports 16550-style FIFO mode and 16450-style single-holding-register mode.

---
 rtl/uart_rx_fifo_if.sv | 40 ++++
 rtl/uart_rx_fifo.sv | 128 ++++++++++++
 tb/tb_uart_rx_fifo.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_if.sv
// Purpose: bundles the receiver-side capture signals and register-side strobes/status of the RX buffer.
// Latency: none; this is wiring only.
// Backpressure: none; the receiver never stalls, and overflow is reported as overrun status.
// Ports: master = receiver + register block (drives done/data/strobes/config), slave = uart_rx_fifo.
interface uart_rx_fifo_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 5
);
  logic              fifo_rst;
  logic              fifo_en;
  logic [1:0]        rx_trig;
  logic              receive_done;
  logic [DATA_W-1:0] rsr_data;
  logic              parity_error;
  logic              frame_error;
  logic              rbr_rd;
  logic              lsr_rd;
  logic [DATA_W-1:0] rbr_data;
  logic              rbr_pe;
  logic              rbr_fe;
  logic              data_ready;
  logic              overrun_error;
  logic              fifo_error;
  logic              trigger_reached;
  logic [CNT_W-1:0]  fifo_count;

  modport master (
    output fifo_rst, fifo_en, rx_trig, receive_done, rsr_data, parity_error,
           frame_error, rbr_rd, lsr_rd,
    input  rbr_data, rbr_pe, rbr_fe, data_ready, overrun_error, fifo_error,
           trigger_reached, fifo_count
  );

  modport slave (
    input  fifo_rst, fifo_en, rx_trig, receive_done, rsr_data, parity_error,
           frame_error, rbr_rd, lsr_rd,
    output rbr_data, rbr_pe, rbr_fe, data_ready, overrun_error, fifo_error,
           trigger_reached, fifo_count
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Purpose: UART RX buffer. Captures each received character with its parity/frame flags into a FIFO or a single holding register.
// Latency: a character is captured at the edge that ends its done-rise cycle, and status reflects it the next cycle; head outputs are combinational.
// Backpressure: none. A write into a full buffer drops the character (FIFO mode) or overwrites it (holding mode), and sets overrun.
// Ports: pclk/presetn, plus bus (slave modport of uart_rx_fifo_if) carrying capture inputs, read strobes and LSR/RBR status.
module uart_rx_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
) (
  input  logic           pclk,
  input  logic           presetn,
  uart_rx_fifo_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = DATA_W + 2;

  typedef logic [ENT_W-1:0] ent_t;

  ent_t mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d, err_cnt_q, err_cnt_d;
  logic             ovr_q, ovr_d;
  logic             done_q, done_d;
  logic             en_q, en_d;
  logic             live_q, live_d;

  ent_t             wr_ent, head;
  logic             empty, wr_ev, rd_ev, clr, at_cap;
  logic             push, pop, ovr_set, ovwr, new_err, head_err;
  logic             mem_we;
  logic [PTR_W-1:0] mem_waddr;
  logic [4:0]       trig_lvl;

  always_comb begin
    wr_ent   = {bus.frame_error, bus.parity_error, bus.rsr_data};
    head     = mem[rd_ptr_q];
    empty    = (count_q == '0);
    // live_q masks the first cycle after reset release so a done held high
    // across reset is absorbed into done_q instead of looking like an edge.
    wr_ev    = live_q & bus.receive_done & ~done_q;
    rd_ev    = bus.rbr_rd & ~empty;
    clr      = bus.fifo_rst | (bus.fifo_en != en_q);
    at_cap   = bus.fifo_en ? (count_q == CNT_W'(DEPTH)) : ~empty;
    // A coincident pop frees a slot, so writing while at capacity still succeeds.
    push     = wr_ev & ~clr & (~at_cap | rd_ev);
    pop      = rd_ev & ~clr;
    ovr_set  = wr_ev & ~clr & at_cap & ~rd_ev;
    ovwr     = ovr_set & ~bus.fifo_en;
    new_err  = |wr_ent[ENT_W-1 -: 2];
    head_err = |head[ENT_W-1 -: 2];

    mem_we    = push | ovwr;
    mem_waddr = ovwr ? rd_ptr_q : wr_ptr_q;

    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    err_cnt_d = err_cnt_q;
    ovr_d     = ovr_q;
    done_d    = bus.receive_done;
    en_d      = bus.fifo_en;
    live_d    = 1'b1;

    if (clr) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      err_cnt_d = '0;
      ovr_d     = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      // The error counter tracks entries with pe|fe; an overwrite retires the
      // old head and adds the new character in one step.
      err_cnt_d = err_cnt_q
                + CNT_W'(push & new_err) - CNT_W'(pop & head_err)
                + CNT_W'(ovwr & new_err) - CNT_W'(ovwr & head_err);
      // A new overrun outranks a coincident LSR read.
      if (ovr_set)         ovr_d = 1'b1;
      else if (bus.lsr_rd) ovr_d = 1'b0;
    end

    case (bus.rx_trig)
      2'b00:   trig_lvl = 5'd1;
      2'b01:   trig_lvl = 5'd4;
      2'b10:   trig_lvl = 5'd8;
      default: trig_lvl = 5'd14;
    endcase

    bus.rbr_data        = empty ? '0 : head[DATA_W-1:0];
    bus.rbr_pe          = ~empty & head[DATA_W];
    bus.rbr_fe          = ~empty & head[DATA_W+1];
    bus.data_ready      = ~empty;
    bus.overrun_error   = ovr_q;
    bus.fifo_error      = (err_cnt_q != '0);
    bus.fifo_count      = count_q;
    bus.trigger_reached = bus.fifo_en ? (32'(count_q) >= 32'(trig_lvl)) : ~empty;
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      err_cnt_q <= '0;
      ovr_q     <= 1'b0;
      done_q    <= 1'b0;
      en_q      <= 1'b0;
      live_q    <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      err_cnt_q <= err_cnt_d;
      ovr_q     <= ovr_d;
      done_q    <= done_d;
      en_q      <= en_d;
      live_q    <= live_d;
    end
  end

  // Storage is unreset; outputs are masked while the buffer is empty.
  always_ff @(posedge pclk) begin
    if (mem_we) mem[mem_waddr] <= wr_ent;
  end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Purpose: self-checking bench for uart_rx_fifo; a queue-based model predicts every output each cycle.
// Latency: the model is stepped on each rising edge, and outputs are compared on the following falling edge.
// Backpressure: none; stimulus includes deliberate overruns, clears and resets.
module tb_uart_rx_fifo;
  localparam int DEPTH  = 16;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 5;

  logic pclk = 1'b0;
  logic presetn;
  always #5 pclk = ~pclk;

  uart_rx_fifo_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus();

  uart_rx_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .pclk    (pclk),
    .presetn (presetn),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference model: a queue of {fe, pe, data} entries plus a sticky overrun bit.
  logic [DATA_W+1:0] q[$];
  bit m_ovr, m_done_prev, m_en_prev, m_started;

  function automatic void model_reset();
    q.delete();
    m_ovr       = 0;
    m_done_prev = 0;
    m_en_prev   = 0;
    m_started   = 0;
  endfunction

  function automatic void model_step();
    bit clr, wr, rd, set_ovr;
    int cap;
    logic [DATA_W+1:0] ent;
    clr = bus.fifo_rst || (bus.fifo_en != m_en_prev);
    wr  = m_started && bus.receive_done && !m_done_prev;
    rd  = bus.rbr_rd && (q.size() != 0);
    ent = {bus.frame_error, bus.parity_error, bus.rsr_data};
    if (clr) begin
      q.delete();
      m_ovr = 0;
    end else begin
      cap = bus.fifo_en ? DEPTH : 1;
      set_ovr = 0;
      if (wr && !rd && q.size() >= cap) begin
        set_ovr = 1;
        if (!bus.fifo_en) q[0] = ent;
      end else begin
        if (rd) void'(q.pop_front());
        if (wr) q.push_back(ent);
      end
      if (set_ovr) m_ovr = 1;
      else if (bus.lsr_rd) m_ovr = 0;
    end
    m_done_prev = bus.receive_done;
    m_en_prev   = bus.fifo_en;
    m_started   = 1;
  endfunction

  task automatic compare_all();
    logic [DATA_W+1:0] h;
    bit any_err;
    int thr;
    h = (q.size() != 0) ? q[0] : '0;
    any_err = 0;
    foreach (q[i]) if (q[i][DATA_W+1] || q[i][DATA_W]) any_err = 1;
    case (bus.rx_trig)
      2'b00: thr = 1;
      2'b01: thr = 4;
      2'b10: thr = 8;
      default: thr = 14;
    endcase
    chk("count",    32'(bus.fifo_count),      32'(q.size()));
    chk("dr",       32'(bus.data_ready),      32'(q.size() != 0));
    chk("oe",       32'(bus.overrun_error),   32'(m_ovr));
    chk("ferr",     32'(bus.fifo_error),      32'(any_err));
    chk("trig",     32'(bus.trigger_reached),
        32'(bus.fifo_en ? (q.size() >= thr) : (q.size() != 0)));
    chk("rbr_data", 32'(bus.rbr_data),        32'(h[DATA_W-1:0]));
    chk("rbr_pe",   32'(bus.rbr_pe),          32'(h[DATA_W]));
    chk("rbr_fe",   32'(bus.rbr_fe),          32'(h[DATA_W+1]));
  endtask

  task automatic tick();
    @(posedge pclk);
    model_step();
    @(negedge pclk);
    compare_all();
  endtask

  task automatic send(input logic [7:0] d, input logic pe, input logic fe);
    bus.rsr_data     = d;
    bus.parity_error = pe;
    bus.frame_error  = fe;
    bus.receive_done = 1'b1;
    tick();
    bus.receive_done = 1'b0;
    tick();
  endtask

  task automatic rd_byte(output logic [7:0] d);
    d = bus.rbr_data;
    bus.rbr_rd = 1'b1;
    tick();
    bus.rbr_rd = 1'b0;
  endtask

  task automatic lsr_pulse();
    bus.lsr_rd = 1'b1;
    tick();
    bus.lsr_rd = 1'b0;
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_count"}, 32'(bus.fifo_count), 0);
    chk({tag, "_dr"},    32'(bus.data_ready), 0);
    chk({tag, "_oe"},    32'(bus.overrun_error), 0);
    chk({tag, "_ferr"},  32'(bus.fifo_error), 0);
    chk({tag, "_trig"},  32'(bus.trigger_reached), 0);
    chk({tag, "_rbr"},   32'({bus.rbr_fe, bus.rbr_pe, bus.rbr_data}), 0);
  endtask

  initial begin
    logic [7:0] d;
    int rd_pct;

    presetn          = 1'b0;
    bus.fifo_rst     = 1'b0;
    bus.fifo_en      = 1'b1;
    bus.rx_trig      = 2'b00;
    bus.receive_done = 1'b0;
    bus.rsr_data     = '0;
    bus.parity_error = 1'b0;
    bus.frame_error  = 1'b0;
    bus.rbr_rd       = 1'b0;
    bus.lsr_rd       = 1'b0;
    model_reset();
    repeat (3) @(negedge pclk);
    all_zero("reset");
    presetn = 1'b1;
    tick();
    tick();

    // In-order delivery of three clean characters.
    send(8'h41, 0, 0);
    send(8'h42, 0, 0);
    send(8'h43, 0, 0);
    chk("t1_count", 32'(bus.fifo_count), 3);
    chk("t1_dr",    32'(bus.data_ready), 1);
    rd_byte(d); chk("t1_rd0", 32'(d), 32'h41);
    rd_byte(d); chk("t1_rd1", 32'(d), 32'h42);
    rd_byte(d); chk("t1_rd2", 32'(d), 32'h43);
    chk("t1_dr_end", 32'(bus.data_ready), 0);

    // Trigger level 4.
    bus.rx_trig = 2'b01;
    send(8'h01, 0, 0); send(8'h02, 0, 0); send(8'h03, 0, 0);
    chk("t2_trig3", 32'(bus.trigger_reached), 0);
    send(8'h04, 0, 0);
    chk("t2_trig4", 32'(bus.trigger_reached), 1);
    rd_byte(d);
    chk("t2_trig_rd", 32'(bus.trigger_reached), 0);
    repeat (3) rd_byte(d);
    bus.rx_trig = 2'b00;

    // Overrun when full, then the same with a coincident read.
    for (int i = 0; i < DEPTH; i++) send(8'(i), 0, 0);
    send(8'h99, 0, 0);
    chk("t3_oe",    32'(bus.overrun_error), 1);
    chk("t3_count", 32'(bus.fifo_count), 16);
    lsr_pulse();
    chk("t3_oe_clr", 32'(bus.overrun_error), 0);
    for (int i = 0; i < DEPTH; i++) begin
      rd_byte(d);
      chk("t3_drain", 32'(d), 32'(i));
    end
    for (int i = 0; i < DEPTH; i++) send(8'hA0 + 8'(i), 0, 0);
    bus.rsr_data = 8'h99;
    bus.receive_done = 1'b1;
    bus.rbr_rd = 1'b1;
    tick();
    bus.rbr_rd = 1'b0;
    bus.receive_done = 1'b0;
    tick();
    chk("t3b_oe",    32'(bus.overrun_error), 0);
    chk("t3b_count", 32'(bus.fifo_count), 16);
    for (int i = 0; i < DEPTH; i++) rd_byte(d);
    chk("t3b_last", 32'(d), 32'h99);

    // Error-in-FIFO tracking.
    send(8'h10, 0, 0);
    send(8'h20, 1, 0);
    send(8'h30, 0, 1);
    chk("t4_ferr0", 32'(bus.fifo_error), 1);
    rd_byte(d); chk("t4_rd10", 32'(d), 32'h10);
    chk("t4_ferr1", 32'(bus.fifo_error), 1);
    chk("t4_pe",    32'(bus.rbr_pe), 1);
    rd_byte(d); chk("t4_rd20", 32'(d), 32'h20);
    chk("t4_ferr2", 32'(bus.fifo_error), 1);
    chk("t4_fe",    32'(bus.rbr_fe), 1);
    rd_byte(d); chk("t4_rd30", 32'(d), 32'h30);
    chk("t4_ferr3", 32'(bus.fifo_error), 0);

    // Holding-register mode overwrite.
    bus.fifo_en = 1'b0;
    tick();
    send(8'h55, 0, 0);
    send(8'h66, 1, 0);
    chk("t5_data",  32'(bus.rbr_data), 32'h66);
    chk("t5_oe",    32'(bus.overrun_error), 1);
    chk("t5_count", 32'(bus.fifo_count), 1);
    chk("t5_ferr",  32'(bus.fifo_error), 1);
    lsr_pulse();
    rd_byte(d);

    // Mode change and fifo_rst clears, coincident character discarded.
    bus.fifo_en = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) send(8'hC0 + 8'(i), i[0], 0);
    bus.fifo_en = 1'b0;
    tick();
    all_zero("t6_mode");
    bus.fifo_en = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) send(8'hD0 + 8'(i), 1, 0);
    send(8'hEE, 0, 0);
    send(8'hEF, 0, 0);
    send(8'hF0, 0, 0);
    send(8'hF1, 0, 0);
    send(8'hF2, 0, 0);
    send(8'hF3, 0, 0);
    send(8'hF4, 0, 0);
    send(8'hF5, 0, 0);
    send(8'hF6, 0, 0);
    send(8'hF7, 0, 0);
    send(8'hF8, 0, 0);
    send(8'hF9, 0, 0);
    chk("t6_oe_pre", 32'(bus.overrun_error), 1);
    bus.fifo_rst = 1'b1;
    bus.rsr_data = 8'h77;
    bus.receive_done = 1'b1;
    tick();
    bus.fifo_rst = 1'b0;
    bus.receive_done = 1'b0;
    tick();
    all_zero("t6_rst");
    send(8'h01, 0, 0);
    rd_byte(d);
    chk("t6_after", 32'(d), 32'h01);

    // Asynchronous reset mid-stream with done held high across release.
    for (int i = 0; i < 5; i++) send(8'h80 + 8'(i), 0, 1);
    bus.receive_done = 1'b1;
    bus.rsr_data = 8'h5A;
    #2;
    presetn = 1'b0;
    #1;
    all_zero("arst");
    model_reset();
    @(negedge pclk);
    @(negedge pclk);
    presetn = 1'b1;
    tick();
    tick();
    bus.receive_done = 1'b0;
    tick();
    chk("arst_nocap", 32'(bus.fifo_count), 0);

    // Randomized traffic in phases of differing read pressure.
    for (int ph = 0; ph < 6; ph++) begin
      case (ph % 3)
        0: rd_pct = 5;
        1: rd_pct = 35;
        default: rd_pct = 70;
      endcase
      if (ph == 4) bus.fifo_en = 1'b0;
      if (ph == 5) bus.fifo_en = 1'b1;
      for (int c = 0; c < 500; c++) begin
        if ($urandom_range(0, 99) < 45) begin
          bus.receive_done = ~bus.receive_done;
          if (bus.receive_done) begin
            bus.rsr_data     = 8'($urandom);
            bus.parity_error = ($urandom_range(0, 99) < 15);
            bus.frame_error  = ($urandom_range(0, 99) < 15);
          end
        end
        bus.rbr_rd   = ($urandom_range(0, 99) < rd_pct);
        bus.lsr_rd   = ($urandom_range(0, 99) < 8);
        bus.fifo_rst = ($urandom_range(0, 999) < 5);
        if ($urandom_range(0, 999) < 5) bus.fifo_en = ~bus.fifo_en;
        if ($urandom_range(0, 99) < 3) bus.rx_trig = 2'($urandom);
        tick();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
